// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the unified memory port arbiter.
// FSM state, grant source and mask width used by the arbiter slice.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  typedef enum logic [0:0] {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } arb_src_e;

  localparam int MASK_W = 4;

  function automatic int cnt_w(input int max);
    return (max < 2) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: saturating up-counter with clear and sat flag.
// Used for fetch starvation tracking and for the optional perf counters.
module mem_arb_starve_ctr #(
  parameter int             W   = 3,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_sat
);

  logic [W-1:0] r_cnt;

  assign o_cnt = r_cnt;
  assign o_sat = (r_cnt == MAX);

  // count up until MAX, clear has priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fetch/data sharing of one single-port memory.
// Optional perf counters enabled by MEM_PORT_ARBITER_PERF_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [MASK_W-1:0] d_mask,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_mask,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_PORT_ARBITER_PERF_EN
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_conflict,
`endif
  output logic              busy
);

  localparam int LAT_W = cnt_w(MEM_LAT);
  localparam int STV_W = cnt_w(STARVE_MAX);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

  arb_state_e       r_state;
  arb_src_e         r_src;
  logic [LAT_W-1:0] r_lat_cnt;

  logic             w_rd_done;
  logic             w_allow;
  logic             w_sat;
  logic             w_rd_issue;
  logic             w_if_lost;
  logic             w_starve_clr;
  logic [STV_W-1:0] w_unused_starve_cnt;

  // read data is on mem_rdata in the last WAIT cycle
  assign w_rd_done = (r_state == WAIT) && (r_lat_cnt == '0);
  // no grants while reset is held, so outputs stay quiet
  assign w_allow   = rst && ((r_state == IDLE) || w_rd_done);

  assign if_gnt = w_allow && if_req && (!d_req || w_sat);
  assign d_gnt  = w_allow && d_req && !(if_req && w_sat);

  assign w_rd_issue   = if_gnt || (d_gnt && !d_we);
  assign w_if_lost    = if_req && !if_gnt;
  assign w_starve_clr = if_gnt || !if_req;

  assign if_rvalid = w_rd_done && (r_src == SRC_IF);
  assign d_rvalid  = w_rd_done && (r_src == SRC_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;
  assign busy      = (r_state == WAIT);

  // drive the memory bus from whichever port won this cycle
  always_comb begin
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_mask  = '0;
    unique case (1'b1)
      d_gnt: begin
        mem_ce    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_mask  = d_mask;
      end
      if_gnt: begin
        mem_ce    = 1'b1;
        mem_addr  = if_addr;
        mem_mask  = {MASK_W{1'b1}};
      end
      default: begin
        mem_ce    = 1'b0;
      end
    endcase
  end

  // track the single outstanding read through the memory latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_lat_cnt <= '0;
      r_src     <= SRC_IF;
    end else if (w_rd_issue) begin
      r_state   <= WAIT;
      r_lat_cnt <= LAT_INIT;
      r_src     <= if_gnt ? SRC_IF : SRC_D;
    end else if (w_rd_done) begin
      r_state   <= IDLE;
    end else if (r_state == WAIT) begin
      r_lat_cnt <= r_lat_cnt - 1'b1;
    end
  end

  mem_arb_starve_ctr #(
    .W   (STV_W),
    .MAX (STV_MAX)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_if_lost),
    .i_clr (w_starve_clr),
    .o_cnt (w_unused_starve_cnt),
    .o_sat (w_sat)
  );

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic w_conflict;
  logic w_unused_wait_sat;
  logic w_unused_conf_sat;

  assign w_conflict = w_allow && if_req && d_req;

  mem_arb_starve_ctr #(
    .W   (32),
    .MAX ('1)
  ) u_perf_wait (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_if_lost),
    .i_clr (1'b0),
    .o_cnt (perf_if_wait),
    .o_sat (w_unused_wait_sat)
  );

  mem_arb_starve_ctr #(
    .W   (32),
    .MAX ('1)
  ) u_perf_conf (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_conflict),
    .i_clr (1'b0),
    .o_cnt (perf_conflict),
    .o_sat (w_unused_conf_sat)
  );
`endif

endmodule
